// File: rtl/ssr_fir_loadable.sv
// Super-sample-rate FIR with a stream-loaded shadow coefficient bank and atomic swap.
// Optional build macro FIR_ROUND_EN: round-half-up before the output shift (default: floor).
module ssr_fir_loadable #(
    parameter int NBITS     = 12,
    parameter int NSAMPS    = 8,
    parameter int NTAPS     = 16,
    parameter int CBITS     = 8,
    parameter int OUT_SHIFT = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NBITS*NSAMPS-1:0] data_i,
    input  logic                    valid_i,
    output logic [NBITS*NSAMPS-1:0] data_o,
    output logic                    valid_o,
    output logic                    sat_o,
    input  logic [CBITS-1:0]        coef_tdata,
    input  logic                    coef_tvalid,
    output logic                    coef_tready,
    input  logic                    coef_tlast,
    output logic                    coef_err,
    output logic                    coef_swapped
);
    localparam int LVL = $clog2(NTAPS);
    localparam int PAD = 1 << LVL;
    localparam int PW  = NBITS + CBITS;
    localparam int AW  = NBITS + CBITS + LVL;
    localparam int LAT = LVL + 2;
    localparam int HB  = (NTAPS - 1 + NSAMPS - 1) / NSAMPS;
    localparam int HW  = ((HB > 0) ? HB : 1) * NSAMPS;
    localparam int CW  = $clog2(NTAPS + 1);
    localparam int IW  = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    localparam logic signed [CBITS-1:0] C_UNITY = CBITS'(1 << OUT_SHIFT);
    localparam logic signed [AW:0]      SMAX    = (AW+1)'((1 << (NBITS-1)) - 1);
    localparam logic signed [AW:0]      SMIN    = ~SMAX;
`ifdef FIR_ROUND_EN
    localparam logic signed [AW:0]      RND     = (AW+1)'((1 << OUT_SHIFT) >> 1);
`else
    localparam logic signed [AW:0]      RND     = '0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SWAP, DROP} state_t;

    function automatic logic [NBITS:0] f_round_sat(input logic signed [AW-1:0] acc);
        logic signed [AW:0]      t;
        logic signed [NBITS-1:0] y;
        logic                    s;
        t = ((AW+1)'(acc) + RND) >>> OUT_SHIFT;
        s = 1'b1;
        if (t > SMAX)      y = SMAX[NBITS-1:0];
        else if (t < SMIN) y = SMIN[NBITS-1:0];
        else begin
            y = t[NBITS-1:0];
            s = 1'b0;
        end
        return {s, y};
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt, w_idx;
    logic                    w_beat, w_set_err, w_shd_we;
    logic signed [CBITS-1:0] r_shd [NTAPS];
    logic signed [CBITS-1:0] r_act [NTAPS];
    logic signed [CBITS-1:0] w_coef [NTAPS];

    logic signed [NBITS-1:0] r_hist [HW];
    logic signed [NBITS-1:0] w_win [HW+NSAMPS];
    logic signed [PW-1:0]    w_prod [NSAMPS][PAD];
    logic signed [AW-1:0]    r_tree_p [NSAMPS][2*PAD-1];
    logic [LAT-2:0]          r_vld_p;
    logic signed [NBITS-1:0] w_y [NSAMPS];
    logic [NSAMPS-1:0]       w_sat;

    // Coefficient load FSM: beats counted from the IDLE beat, length judged at beat NTAPS or tlast
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_set_err   = 1'b0;
        w_shd_we    = 1'b0;
        coef_tready = (r_state != SWAP);
        w_idx       = (r_state == IDLE) ? '0 : r_cnt;
        w_beat      = coef_tvalid && coef_tready;
        case (r_state)
            IDLE, LOAD: begin
                if (w_beat) begin
                    w_shd_we  = 1'b1;
                    w_cnt_nxt = w_idx + CW'(1);
                    if (w_idx == CW'(NTAPS - 1)) begin
                        if (coef_tlast) begin
                            w_state_nxt = SWAP;
                        end else begin
                            w_set_err   = 1'b1;
                            w_state_nxt = DROP;
                        end
                    end else if (coef_tlast) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            SWAP:    w_state_nxt = IDLE;
            DROP:    if (w_beat && coef_tlast) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            coef_err     <= 1'b0;
            coef_swapped <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                r_shd[k] <= '0;
                r_act[k] <= (k == 0) ? C_UNITY : '0;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            coef_swapped <= (r_state == SWAP);
            if (r_state == SWAP) coef_err <= 1'b0;
            else if (w_set_err)  coef_err <= 1'b1;
            if (w_shd_we) r_shd[IW'(w_idx)] <= coef_tdata;
            if (r_state == SWAP) begin
                for (int k = 0; k < NTAPS; k++) r_act[k] <= r_shd[k];
            end
        end
    end

    // The block captured on the swap edge already sees the shadow set, keeping the swap block-atomic
    always_comb begin
        for (int k = 0; k < NTAPS; k++) w_coef[k] = (r_state == SWAP) ? r_shd[k] : r_act[k];
        for (int i = 0; i < HW; i++) w_win[i] = r_hist[i];
        for (int ln = 0; ln < NSAMPS; ln++) w_win[HW+ln] = data_i[NBITS*ln +: NBITS];
        for (int ln = 0; ln < NSAMPS; ln++) begin
            for (int k = 0; k < PAD; k++) w_prod[ln][k] = '0;
            for (int k = 0; k < NTAPS; k++)
                w_prod[ln][k] = PW'(w_win[HW+ln-k]) * PW'(w_coef[k]);
        end
    end

    // Stage p0: products into tree leaves; following LVL stages reduce pairs toward node 0
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < HW; i++) r_hist[i] <= '0;
            for (int ln = 0; ln < NSAMPS; ln++)
                for (int i = 0; i < 2*PAD-1; i++) r_tree_p[ln][i] <= '0;
            r_vld_p <= '0;
        end else begin
            for (int i = 0; i < HW; i++) r_hist[i] <= w_win[i+NSAMPS];
            for (int ln = 0; ln < NSAMPS; ln++) begin
                for (int k = 0; k < PAD; k++) r_tree_p[ln][PAD-1+k] <= AW'(w_prod[ln][k]);
                for (int i = 0; i < PAD-1; i++)
                    r_tree_p[ln][i] <= r_tree_p[ln][2*i+1] + r_tree_p[ln][2*i+2];
            end
            r_vld_p[0] <= valid_i;
            for (int j = 1; j < LAT-1; j++) r_vld_p[j] <= r_vld_p[j-1];
        end
    end

    always_comb begin
        for (int ln = 0; ln < NSAMPS; ln++) {w_sat[ln], w_y[ln]} = f_round_sat(r_tree_p[ln][0]);
    end

    // Final stage: shift, round and saturate
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_o  <= '0;
            sat_o   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            for (int ln = 0; ln < NSAMPS; ln++) data_o[NBITS*ln +: NBITS] <= w_y[ln];
            sat_o   <= |w_sat;
            valid_o <= r_vld_p[LAT-2];
        end
    end
endmodule

// File: tb/tb_ssr_fir_loadable.sv
// Randomised bench for ssr_fir_loadable against a direct-convolution sample-stream model.
module tb_ssr_fir_loadable;
    localparam int NBITS = 12, NSAMPS = 8, NTAPS = 16, CBITS = 8, OUT_SHIFT = 4;
    localparam int LAT = $clog2(NTAPS) + 2;
    localparam int W   = NBITS * NSAMPS;

    typedef struct packed { logic [W-1:0] d; logic v; logic s; } rec_t;

    logic             aclk = 1'b0, aresetn = 1'b0;
    logic [W-1:0]     data_i = '0, data_o;
    logic             valid_i = 1'b0, valid_o, sat_o;
    logic [CBITS-1:0] coef_tdata = '0;
    logic             coef_tvalid = 1'b0, coef_tready, coef_tlast = 1'b0, coef_err, coef_swapped;

    ssr_fir_loadable #(.NBITS(NBITS), .NSAMPS(NSAMPS), .NTAPS(NTAPS), .CBITS(CBITS),
                       .OUT_SHIFT(OUT_SHIFT)) dut (
        .aclk(aclk), .aresetn(aresetn), .data_i(data_i), .valid_i(valid_i),
        .data_o(data_o), .valid_o(valid_o), .sat_o(sat_o),
        .coef_tdata(coef_tdata), .coef_tvalid(coef_tvalid), .coef_tready(coef_tready),
        .coef_tlast(coef_tlast), .coef_err(coef_err), .coef_swapped(coef_swapped));

    always #5 aclk = ~aclk;

    int   checks = 0, failures = 0, swap_cnt = 0;
    int   hx[$];
    int   mh [NTAPS];
    int   ld_h [64];
    rec_t exp_q[$], obs_q[$];

    function automatic void model_reset();
        hx.delete(); exp_q.delete(); obs_q.delete();
        for (int k = 0; k < NTAPS; k++) mh[k] = (k == 0) ? (1 << OUT_SHIFT) : 0;
    endfunction

    function automatic logic [W-1:0] rand_blk();
        logic [W-1:0] b;
        for (int ln = 0; ln < NSAMPS; ln++) b[NBITS*ln +: NBITS] = NBITS'($urandom_range(0, 4095));
        return b;
    endfunction

    function automatic void rand_taps();
        for (int k = 0; k < 64; k++) ld_h[k] = int'($urandom_range(0, 255)) - 128;
    endfunction

    // y[n] = sum h[k]*x[n-k], then shift/round/saturate, all in plain integer arithmetic
    task automatic drive_cycle(input logic [W-1:0] blk, input logic vld);
        rec_t e;
        logic signed [NBITS-1:0] smp;
        longint acc, y;
        int base;
        data_i = blk; valid_i = vld;
        for (int ln = 0; ln < NSAMPS; ln++) begin
            smp = blk[NBITS*ln +: NBITS];
            hx.push_back(int'(smp));
        end
        base = hx.size() - NSAMPS;
        e.v = vld; e.s = 1'b0; e.d = '0;
        for (int ln = 0; ln < NSAMPS; ln++) begin
            acc = 0;
            for (int k = 0; k < NTAPS; k++)
                if (base + ln - k >= 0) acc += longint'(mh[k]) * longint'(hx[base+ln-k]);
`ifdef FIR_ROUND_EN
            acc += (1 << OUT_SHIFT) / 2;
`endif
            y = acc >>> OUT_SHIFT;
            if (y > 2047)  begin y = 2047;  e.s = 1'b1; end
            if (y < -2048) begin y = -2048; e.s = 1'b1; end
            e.d[NBITS*ln +: NBITS] = NBITS'(y);
        end
        exp_q.push_back(e);
        @(posedge aclk); #1;
        obs_q.push_back({data_o, valid_o, sat_o});
        if (coef_swapped === 1'b1) swap_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle('0, 1'b0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0; coef_tvalid = 1'b0; coef_tlast = 1'b0; valid_i = 1'b0; data_i = '0;
        repeat (2) @(posedge aclk);
        #1; aresetn = 1'b1;
        model_reset();
    endtask

    // nb beats from ld_h, tlast on beat lastb, asynchronous reset pulse instead of beat rst_at
    task automatic load(input int nb, input int lastb, input int rst_at);
        for (int b = 1; b <= nb; b++) begin
            coef_tvalid = 1'b1; coef_tdata = CBITS'(ld_h[b-1]); coef_tlast = (b == lastb);
            if (b == rst_at) begin
                aresetn = 1'b0; #2; aresetn = 1'b1;
                coef_tvalid = 1'b0; coef_tlast = 1'b0;
                model_reset();
                return;
            end
            drive_cycle(rand_blk(), 1'($urandom_range(0, 1)));
        end
        coef_tvalid = 1'b0; coef_tlast = 1'b0;
        if (nb == NTAPS && lastb == NTAPS)
            for (int k = 0; k < NTAPS; k++) mh[k] = ld_h[k];
    endtask

    task automatic test_reset();
        aresetn = 1'b0; #3;
        checks++; if (data_o !== '0) begin failures++; $display("FAIL rst_data got %h want 0", data_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got %b want 0", valid_o); end
        checks++; if (sat_o !== 1'b0) begin failures++; $display("FAIL rst_sat got %b want 0", sat_o); end
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL rst_err got %b want 0", coef_err); end
        checks++; if (coef_swapped !== 1'b0) begin failures++; $display("FAIL rst_swapped got %b want 0", coef_swapped); end
        checks++; if (coef_tready !== 1'b1) begin failures++; $display("FAIL rst_tready got %b want 1", coef_tready); end
        do_reset();
    endtask

    task automatic test_identity();
        logic [W-1:0] blk;
        exp_q.delete(); obs_q.delete();
        blk = '0; blk[NBITS*3 +: NBITS] = NBITS'(100);
        drive_cycle(blk, 1'b1);
        repeat (20) drive_cycle(rand_blk(), 1'($urandom_range(0, 1)));
        idle(LAT - 1);
        checks++;
        if (obs_q[LAT-1] !== {blk, 1'b1, 1'b0}) begin
            failures++; $display("FAIL ident_impulse got %h want %h", obs_q[LAT-1], {blk, 1'b1, 1'b0});
        end
        for (int i = 0; i + LAT - 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i+LAT-1] !== exp_q[i]) begin
                failures++; $display("FAIL ident_stream blk%0d got %h want %h", i, obs_q[i+LAT-1], exp_q[i]);
            end
        end
    endtask

    task automatic test_load_taps();
        logic [W-1:0] blk;
        int sc, bi;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 64; k++) ld_h[k] = 0;
        ld_h[0] = 16; ld_h[1] = -32; ld_h[2] = 8; ld_h[3] = 19;
        sc = swap_cnt;
        load(NTAPS, NTAPS, 0);
        checks++; if (coef_tready !== 1'b0) begin failures++; $display("FAIL swap_tready got %b want 0", coef_tready); end
        drive_cycle(rand_blk(), 1'b1);
        checks++; if (coef_swapped !== 1'b1) begin failures++; $display("FAIL swap_pulse got %b want 1", coef_swapped); end
        repeat (4) drive_cycle(rand_blk(), 1'b1);
        idle(3);
        bi = exp_q.size();
        blk = '0; blk[NBITS*7 +: NBITS] = NBITS'(1000);
        drive_cycle(blk, 1'b1);
        drive_cycle('0, 1'b1);
        idle(LAT);
        checks++; if (swap_cnt - sc !== 1) begin failures++; $display("FAIL swap_count got %0d want 1", swap_cnt - sc); end
        checks++;
        if (obs_q[bi+LAT-1].d[NBITS*7 +: NBITS] !== NBITS'(1000)) begin
            failures++; $display("FAIL tap_h0 got %0d want 1000", $signed(obs_q[bi+LAT-1].d[NBITS*7 +: NBITS]));
        end
        checks++;
        if (obs_q[bi+LAT].d[NBITS*0 +: NBITS] !== NBITS'(-2000) || obs_q[bi+LAT].d[NBITS*1 +: NBITS] !== NBITS'(500)) begin
            failures++; $display("FAIL tap_h1h2 got %0d,%0d want -2000,500",
                $signed(obs_q[bi+LAT].d[0 +: NBITS]), $signed(obs_q[bi+LAT].d[NBITS +: NBITS]));
        end
        for (int i = 0; i + LAT - 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i+LAT-1] !== exp_q[i]) begin
                failures++; $display("FAIL load_stream blk%0d got %h want %h", i, obs_q[i+LAT-1], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] b1, b2;
        int bi;
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 64; k++) ld_h[k] = 0;
        ld_h[0] = 127;
        load(NTAPS, NTAPS, 0);
        idle(3);
        bi = exp_q.size();
        b1 = '0; b1[0 +: NBITS] = NBITS'(2047);
        b2 = '0; b2[0 +: NBITS] = NBITS'(-2048);
        drive_cycle(b1, 1'b1);
        drive_cycle(b2, 1'b1);
        repeat (10) drive_cycle(rand_blk(), 1'b1);
        idle(LAT - 1);
        checks++;
        if (obs_q[bi+LAT-1] !== {b1, 1'b1, 1'b1}) begin
            failures++; $display("FAIL sat_pos got %h want %h", obs_q[bi+LAT-1], {b1, 1'b1, 1'b1});
        end
        checks++;
        if (obs_q[bi+LAT] !== {b2, 1'b1, 1'b1}) begin
            failures++; $display("FAIL sat_neg got %h want %h", obs_q[bi+LAT], {b2, 1'b1, 1'b1});
        end
        for (int i = 0; i + LAT - 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i+LAT-1] !== exp_q[i]) begin
                failures++; $display("FAIL sat_stream blk%0d got %h want %h", i, obs_q[i+LAT-1], exp_q[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [W-1:0] blk;
        logic [NBITS-1:0] wp, wn;
        int bi;
`ifdef FIR_ROUND_EN
        wp = NBITS'(2);  wn = NBITS'(-1);
`else
        wp = NBITS'(1);  wn = NBITS'(-2);
`endif
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 64; k++) ld_h[k] = 0;
        ld_h[0] = 8;
        load(NTAPS, NTAPS, 0);
        idle(3);
        bi = exp_q.size();
        blk = '0; blk[0 +: NBITS] = NBITS'(3); blk[NBITS +: NBITS] = NBITS'(-3);
        drive_cycle(blk, 1'b1);
        repeat (8) drive_cycle(rand_blk(), 1'b1);
        idle(LAT - 1);
        checks++;
        if (obs_q[bi+LAT-1].d[0 +: NBITS] !== wp) begin
            failures++; $display("FAIL round_pos got %0d want %0d", $signed(obs_q[bi+LAT-1].d[0 +: NBITS]), $signed(wp));
        end
        checks++;
        if (obs_q[bi+LAT-1].d[NBITS +: NBITS] !== wn) begin
            failures++; $display("FAIL round_neg got %0d want %0d", $signed(obs_q[bi+LAT-1].d[NBITS +: NBITS]), $signed(wn));
        end
        for (int i = 0; i + LAT - 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i+LAT-1] !== exp_q[i]) begin
                failures++; $display("FAIL round_stream blk%0d got %h want %h", i, obs_q[i+LAT-1], exp_q[i]);
            end
        end
    endtask

    task automatic test_length_error();
        int sc;
        exp_q.delete(); obs_q.delete();
        sc = swap_cnt;
        rand_taps();
        load(5, 5, 0);
        checks++; if (coef_err !== 1'b1) begin failures++; $display("FAIL err_short got %b want 1", coef_err); end
        repeat (6) drive_cycle(rand_blk(), 1'b1);
        rand_taps();
        load(18, 18, 0);
        checks++; if (coef_err !== 1'b1) begin failures++; $display("FAIL err_long got %b want 1", coef_err); end
        checks++; if (coef_tready !== 1'b1) begin failures++; $display("FAIL err_tready got %b want 1", coef_tready); end
        repeat (6) drive_cycle(rand_blk(), 1'b1);
        checks++; if (swap_cnt !== sc) begin failures++; $display("FAIL err_noswap got %0d want %0d", swap_cnt, sc); end
        rand_taps();
        load(NTAPS, NTAPS, 0);
        drive_cycle(rand_blk(), 1'b1);
        checks++; if (coef_err !== 1'b0) begin failures++; $display("FAIL err_clear got %b want 0", coef_err); end
        repeat (12) drive_cycle(rand_blk(), 1'($urandom_range(0, 1)));
        idle(LAT - 1);
        for (int i = 0; i + LAT - 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i+LAT-1] !== exp_q[i]) begin
                failures++; $display("FAIL err_stream blk%0d got %h want %h", i, obs_q[i+LAT-1], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int sc;
        rand_taps();
        load(NTAPS, NTAPS, 9);
        checks++; if (coef_tready !== 1'b1) begin failures++; $display("FAIL midrst_tready got %b want 1", coef_tready); end
        checks++; if (data_o !== '0) begin failures++; $display("FAIL midrst_data got %h want 0", data_o); end
        repeat (10) drive_cycle(rand_blk(), 1'b1);
        sc = swap_cnt;
        rand_taps();
        load(NTAPS, NTAPS, 0);
        repeat (12) drive_cycle(rand_blk(), 1'($urandom_range(0, 1)));
        idle(LAT - 1);
        checks++; if (swap_cnt - sc !== 1) begin failures++; $display("FAIL midrst_swap got %0d want 1", swap_cnt - sc); end
        for (int i = 0; i + LAT - 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i+LAT-1] !== exp_q[i]) begin
                failures++; $display("FAIL midrst_stream blk%0d got %h want %h", i, obs_q[i+LAT-1], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sc;
        exp_q.delete(); obs_q.delete();
        sc = swap_cnt;
        rand_taps();
        load(NTAPS, NTAPS, 0);
        drive_cycle(rand_blk(), 1'b1);
        rand_taps();
        load(NTAPS, NTAPS, 0);
        repeat (10) drive_cycle(rand_blk(), 1'b1);
        idle(LAT - 1);
        checks++; if (swap_cnt - sc !== 2) begin failures++; $display("FAIL b2b_swaps got %0d want 2", swap_cnt - sc); end
        for (int i = 0; i + LAT - 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i+LAT-1] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_stream blk%0d got %h want %h", i, obs_q[i+LAT-1], exp_q[i]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_identity();
        test_load_taps();
        test_saturation();
        test_rounding();
        test_length_error();
        test_reset_mid_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
